// File: rtl/smm1_job_dispatch.sv
// Job initiator for the level-1 Strassen multiply controller: accepts tagged jobs, pulses load,
// tracks ack/done strobes with timeouts, and returns tagged results through a 2-entry response FIFO.
module smm1_job_dispatch #(
  parameter int ID_W         = 4,
  parameter int RES_W        = 64,
  parameter int ACK_TIMEOUT  = 4,
  parameter int DONE_TIMEOUT = 16,
  parameter int LAT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ID_W-1:0]  req_id,
  output logic             smm_load,
  input  logic             smm_ack,
  input  logic             smm_done,
  input  logic [RES_W-1:0] smm_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic [LAT_W-1:0] rsp_lat,
  output logic             spurious
);

  localparam int TMAX  = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int TMR_W = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [RES_W-1:0] data;
    logic             err;
    logic [LAT_W-1:0] lat;
  } rsp_t;

  state_t           state;
  logic [ID_W-1:0]  cur_id;
  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] lat_inc;
  logic [TMR_W-1:0] tmr;
  logic             run;
  logic [1:0]       cnt;
  rsp_t             e0, e1;
  rsp_t             push_e;
  logic             push, pop, accept;

  // Nothing is in flight while in IDLE, so a free FIFO slot is enough to guarantee room.
  assign req_ready = run && (state == IDLE) && (cnt < 2'd2);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign lat_inc   = (&lat) ? lat : lat + 1'b1;

  // Done is honoured in WAIT_ACK too, so a same-cycle ack+done completes normally;
  // a strobe always beats the timeout that expires in the same cycle.
  always_comb begin
    push        = 1'b0;
    push_e      = '0;
    push_e.id   = cur_id;
    push_e.lat  = lat;
    case (state)
      WAIT_ACK: begin
        if (smm_done) begin
          push        = 1'b1;
          push_e.data = smm_result;
        end else if (!smm_ack && tmr == TMR_W'(ACK_TIMEOUT)) begin
          push       = 1'b1;
          push_e.err = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (smm_done) begin
          push        = 1'b1;
          push_e.data = smm_result;
        end else if (tmr == TMR_W'(DONE_TIMEOUT)) begin
          push       = 1'b1;
          push_e.err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      smm_load <= 1'b0;
      cur_id   <= '0;
      lat      <= '0;
      tmr      <= '0;
      run      <= 1'b0;
      spurious <= 1'b0;
    end else begin
      run      <= 1'b1;
      smm_load <= 1'b0;
      if ((smm_ack && state != WAIT_ACK) ||
          (smm_done && state != WAIT_ACK && state != WAIT_DONE))
        spurious <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_id   <= req_id;
            smm_load <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          lat   <= LAT_W'(1);
          tmr   <= TMR_W'(1);
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          lat <= lat_inc;
          if (push) begin
            state <= IDLE;
          end else if (smm_ack) begin
            tmr   <= TMR_W'(1);
            state <= WAIT_DONE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        WAIT_DONE: begin
          lat <= lat_inc;
          if (push) state <= IDLE;
          else      tmr   <= tmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift-style FIFO: e0 is always the head, so rsp_* come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_e;
          else             e1 <= push_e;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          e0  <= e1;
          e1  <= '0;
          cnt <= cnt - 1'b1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= push_e;
          end else begin
            e0 <= e1;
            e1 <= push_e;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (cnt != 2'd0);
  assign rsp_id    = e0.id;
  assign rsp_data  = e0.data;
  assign rsp_err   = e0.err;
  assign rsp_lat   = e0.lat;

endmodule

// File: tb/tb_smm1_job_dispatch.sv
// Directed bench for smm1_job_dispatch: the bench plays the multiply controller and the
// response consumer, with expected values worked out by hand.
module tb_smm1_job_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_id = '0;
  logic        smm_load;
  logic        smm_ack = 1'b0;
  logic        smm_done = 1'b0;
  logic [63:0] smm_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  rsp_lat;
  logic        spurious;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  smm1_job_dispatch #(
    .ID_W(4), .RES_W(64), .ACK_TIMEOUT(4), .DONE_TIMEOUT(16), .LAT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .smm_load(smm_load), .smm_ack(smm_ack), .smm_done(smm_done), .smm_result(smm_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_lat(rsp_lat), .spurious(spurious)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; load cycle is k=0, strobes are driven for cycles k=1..ncyc.
  // Returns at the negedge of cycle ncyc+1 with strobes cleared.
  task automatic job(input logic [3:0] id, input logic [63:0] res,
                     input int ack_k, input int done_k, input int ncyc);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_id    = id;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("req_wait", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("load_pulse", smm_load, 1);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) chk("load_once", smm_load, 0);
      smm_ack    = (k == ack_k);
      smm_done   = (k == done_k);
      smm_result = (k == done_k) ? res : '0;
    end
    @(negedge clk);
    smm_ack    = 1'b0;
    smm_done   = 1'b0;
    smm_result = '0;
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_load", smm_load, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_lat", rsp_lat, 0);
    chk("rst_spur", spurious, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // 1: nominal job, ack at k=2, done at k=8
    job(4'd3, 64'h0011_2233_4455_6677, 2, 8, 8);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 3);
    chk("t1_data", rsp_data, 64'h0011_2233_4455_6677);
    chk("t1_err", rsp_err, 0);
    chk("t1_lat", rsp_lat, 8);
    chk("t1_load_idle", smm_load, 0);
    chk("t1_spur", spurious, 0);
    pop_one();
    chk("t1_popped", rsp_valid, 0);

    // 6: ack and done in the same cycle (k=3)
    job(4'd4, 64'hCAFE_0000_BEEF_1111, 3, 3, 3);
    chk("t6_valid", rsp_valid, 1);
    chk("t6_id", rsp_id, 4);
    chk("t6_data", rsp_data, 64'hCAFE_0000_BEEF_1111);
    chk("t6_err", rsp_err, 0);
    chk("t6_lat", rsp_lat, 3);
    chk("t6_spur", spurious, 0);
    pop_one();

    // 2: two jobs held back by rsp_ready=0 fill the FIFO
    job(4'd5, 64'hAAAA_0001_AAAA_0002, 2, 8, 8);
    job(4'd6, 64'hBBBB_0003_BBBB_0004, 2, 8, 8);
    chk("t2_head_id", rsp_id, 5);
    chk("t2_head_data", rsp_data, 64'hAAAA_0001_AAAA_0002);
    req_valid = 1'b1;
    req_id    = 4'd7;
    chk("t2_full_ready", req_ready, 0);
    @(negedge clk);
    chk("t2_full_ready2", req_ready, 0);
    chk("t2_no_load", smm_load, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_reready", req_ready, 1);
    req_valid = 1'b0;
    chk("t2_next_id", rsp_id, 6);
    chk("t2_next_data", rsp_data, 64'hBBBB_0003_BBBB_0004);
    chk("t2_next_lat", rsp_lat, 8);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t2_drained", rsp_valid, 0);
    chk("t2_no_issue", smm_load, 0);

    // 3: no ack -> error after 4 waiting cycles (lat=4); late ack is spurious
    job(4'd9, 64'h1234_5678_9ABC_DEF0, 0, 0, 6);
    chk("t3_valid", rsp_valid, 1);
    chk("t3_id", rsp_id, 9);
    chk("t3_err", rsp_err, 1);
    chk("t3_data", rsp_data, 0);
    chk("t3_lat", rsp_lat, 4);
    chk("t3_spur_pre", spurious, 0);
    smm_ack = 1'b1;
    @(negedge clk);
    smm_ack = 1'b0;
    chk("t3_spur", spurious, 1);
    pop_one();
    chk("t3_no_push", rsp_valid, 0);

    // Reset to clear the sticky flag before the done-timeout case
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_spur", spurious, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4: ack at k=2, done withheld -> timeout 16 cycles into WAIT_DONE (k=18)
    job(4'd11, 64'hFFFF_EEEE_DDDD_CCCC, 2, 0, 19);
    chk("t4_valid", rsp_valid, 1);
    chk("t4_id", rsp_id, 11);
    chk("t4_err", rsp_err, 1);
    chk("t4_data", rsp_data, 0);
    chk("t4_lat", rsp_lat, 18);
    chk("t4_spur_pre", spurious, 0);
    pop_one();
    chk("t4_popped", rsp_valid, 0);
    smm_done   = 1'b1;
    smm_result = 64'h5555_5555_5555_5555;
    @(negedge clk);
    smm_done   = 1'b0;
    smm_result = '0;
    chk("t4_spur", spurious, 1);
    @(negedge clk);
    chk("t4_no_push", rsp_valid, 0);

    // 5: asynchronous reset in WAIT_DONE
    job(4'd12, 64'h0F0F_0F0F_0F0F_0F0F, 2, 0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_load", smm_load, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_valid", rsp_valid, 0);
    chk("t5_lat", rsp_lat, 0);
    chk("t5_spur", spurious, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_empty", rsp_valid, 0);
    job(4'd13, 64'h1357_9BDF_2468_ACE0, 2, 8, 8);
    chk("t5_id", rsp_id, 13);
    chk("t5_data", rsp_data, 64'h1357_9BDF_2468_ACE0);
    chk("t5_err", rsp_err, 0);
    chk("t5_lat2", rsp_lat, 8);
    pop_one();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
